reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- Architectural integer register file for the 64-bit RISC-V pipeline, with an in-flight write scoreboard.
- Consumes the write-back port: rd index, rd data and rd write-enable, registered outputs of the write-back stage.
- Serves two combinational read ports to decode, with a same-cycle write-through bypass.
- Per-register pending-write counters raise a RAW hazard when a source register still has an outstanding write.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers; index width is clog2(NREGS)=5.
- CNT_W, 2, width of each pending-write counter; maximum outstanding writes per register is 2^CNT_W-1 = 3.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_rd_index  input  5  write-back destination index.
- i_rd_data  input  XLEN  write-back data.
- i_rd_we  input  1  write-back enable.
- i_rs1_index  input  5  read port 1 index.
- i_rs2_index  input  5  read port 2 index.
- i_rs1_used  input  1  decoded instruction reads rs1.
- i_rs2_used  input  1  decoded instruction reads rs2.
- o_rs1_data  output  XLEN  read port 1 data.
- o_rs2_data  output  XLEN  read port 2 data.
- o_hazard  output  1  RAW hazard; decode must stall.
- i_issue_valid  input  1  instruction leaves decode this cycle.
- i_issue_rd  input  5  destination of the issuing instruction.
- i_issue_we  input  1  issuing instruction writes rd.
- o_issue_full  output  1  counter for i_issue_rd saturated; decode must not issue.
- o_sb_underflow  output  1  sticky error: write-back arrived with counter at 0.

Behaviour:
- Reset (async, i_rst=1): all registers=0, all counters=0, o_sb_underflow=0. Combinational outputs follow from the reset state: o_hazard=0, o_issue_full=0, reads return 0.
- Write: at posedge, if i_rd_we && i_rd_index!=0, then regs[i_rd_index] <= i_rd_data. Writes to x0 are discarded.
- Read (combinational):
  - index 0 -> 0.
  - else if i_rd_we && i_rd_index==index -> i_rd_data (bypass).
  - else regs[index].
- Counter events (x0 never counted):
  - inc = i_issue_valid && i_issue_we && i_issue_rd!=0 && !o_issue_full.
  - dec = i_rd_we && i_rd_index!=0.
- Counter update at posedge:
  - inc and dec on different regs: each applied independently.
  - inc and dec on the same reg: count unchanged.
  - dec with count==0: count stays 0, o_sb_underflow <= 1 (sticky until reset). The data write is still performed.
- o_issue_full = (i_issue_rd!=0) && cnt[i_issue_rd]==max. An issue while o_issue_full is ignored by the counters.
- Per-source hazard = used && index!=0 && cnt[index]!=0 && !(dec on index && cnt[index]==1).
  - The exception covers the final pending write, which resolves via the bypass in the same cycle.
  - o_hazard = hazard_rs1 | hazard_rs2.
- An issue in the same cycle does not affect that cycle's hazard; the counter change is visible from the next cycle.
- Reset asserted mid-operation clears everything immediately; in-flight write-backs arriving after reset count as underflow.

Decomposition:
- Shared package rv_pkg: XLEN, NREGS, REG_IDX_W=5, CNT_W, and the typedef reg_idx_t (logic [4:0]).
- One natural sub-module, sb_counter: a single saturating up/down counter with inc, dec, full, nonzero and underflow outputs. It is instantiated NREGS-1 times via generate.
- Register array and read/bypass mux stay in the top module.

Test Plan:
- Reset: assert i_rst mid-cycle -> o_rs1_data=0 for x5, o_hazard=0, o_sb_underflow=0 immediately (asynchronous).
- Write/read and x0:
  - Write x7=64'hDEAD_BEEF_0123_4567 -> next cycle rs1=7 returns that value.
  - Write x0=64'hFFFF... -> rs1=0 returns 0.
- Bypass: i_rd_we=1, i_rd_index=9, i_rd_data=64'h55 while rs2=9 -> o_rs2_data=64'h55 in the same cycle.
- Hazard lifecycle:
  - Issue rd=3 -> next cycle rs1=3 used gives o_hazard=1.
  - Write-back x3 -> o_hazard=0 that cycle via bypass, counter back to 0.
  - Same sequence with i_rs1_used=0 -> o_hazard=0 throughout.
- Saturation:
  - Issue rd=4 three times -> o_issue_full=1 for rd=4; a fourth issue is ignored.
  - Three write-backs to x4 -> counter 0.
  - Simultaneous issue and write-back to x4 at count 2 -> stays 2.
- Underflow: write-back x12 with no issue -> data written, o_sb_underflow=1 and stays 1 until i_rst.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared widths and index type for the integer register file and its
// pending-write scoreboard.
package rv_pkg;
  localparam int XLEN      = 64;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);
  localparam int CNT_W     = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Write-back, decode-read and issue signals between the pipeline (master)
// and the register file / scoreboard (slave).
interface reg_file_scoreboard_if;
  import rv_pkg::*;

  reg_idx_t        i_rd_index;
  logic [XLEN-1:0] i_rd_data;
  logic            i_rd_we;
  reg_idx_t        i_rs1_index;
  reg_idx_t        i_rs2_index;
  logic            i_rs1_used;
  logic            i_rs2_used;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic            o_hazard;
  logic            i_issue_valid;
  reg_idx_t        i_issue_rd;
  logic            i_issue_we;
  logic            o_issue_full;
  logic            o_sb_underflow;

  modport slave (
    input  i_rd_index, i_rd_data, i_rd_we,
    input  i_rs1_index, i_rs2_index, i_rs1_used, i_rs2_used,
    input  i_issue_valid, i_issue_rd, i_issue_we,
    output o_rs1_data, o_rs2_data, o_hazard, o_issue_full, o_sb_underflow
  );

  modport master (
    output i_rd_index, i_rd_data, i_rd_we,
    output i_rs1_index, i_rs2_index, i_rs1_used, i_rs2_used,
    output i_issue_valid, i_issue_rd, i_issue_we,
    input  o_rs1_data, o_rs2_data, o_hazard, o_issue_full, o_sb_underflow
  );
endinterface

// File: rtl/reg_file_scoreboard_sb_counter.sv
// Saturating pending-write counter for one architectural register: counts
// issued writes up and completed write-backs down.
module sb_counter
  import rv_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_nonzero,
  output logic o_last,
  output logic o_underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_inc;

  assign w_inc       = i_inc && !o_full;
  assign o_full      = (r_cnt == CNT_MAX);
  assign o_nonzero   = (r_cnt != '0);
  assign o_last      = (r_cnt == CNT_W'(1));
  assign o_underflow = i_dec && (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_inc && !i_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !w_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/reg_file_scoreboard.sv
// Integer register file with write-through bypass and a per-register
// pending-write scoreboard that flags RAW hazards to decode.
module reg_file_scoreboard
  import rv_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  reg_file_scoreboard_if.slave bus
);
  logic [XLEN-1:0]  r_regs [NREGS];
  logic             r_sb_underflow;
  logic [NREGS-1:0] w_full;
  logic [NREGS-1:0] w_nonzero;
  logic [NREGS-1:0] w_last;
  logic [NREGS-1:0] w_underflow;
  logic             w_wb;
  logic             w_issue_ok;
  logic             w_hazard_rs1;
  logic             w_hazard_rs2;

  assign w_wb       = bus.i_rd_we && (bus.i_rd_index != '0);
  assign w_issue_ok = bus.i_issue_valid && bus.i_issue_we &&
                      (bus.i_issue_rd != '0) && !bus.o_issue_full;

  // x0 has no counter; its status bits are constant zero.
  assign w_full[0]      = 1'b0;
  assign w_nonzero[0]   = 1'b0;
  assign w_last[0]      = 1'b0;
  assign w_underflow[0] = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    logic w_inc;
    logic w_dec;
    assign w_inc = w_issue_ok && (bus.i_issue_rd == REG_IDX_W'(g));
    assign w_dec = w_wb && (bus.i_rd_index == REG_IDX_W'(g));

    sb_counter u_cnt (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_inc       (w_inc),
      .i_dec       (w_dec),
      .o_full      (w_full[g]),
      .o_nonzero   (w_nonzero[g]),
      .o_last      (w_last[g]),
      .o_underflow (w_underflow[g])
    );
  end

  assign bus.o_issue_full = (bus.i_issue_rd != '0) && w_full[bus.i_issue_rd];

  assign bus.o_rs1_data = (bus.i_rs1_index == '0) ? '0 :
                          (w_wb && bus.i_rd_index == bus.i_rs1_index) ? bus.i_rd_data :
                          r_regs[bus.i_rs1_index];
  assign bus.o_rs2_data = (bus.i_rs2_index == '0) ? '0 :
                          (w_wb && bus.i_rd_index == bus.i_rs2_index) ? bus.i_rd_data :
                          r_regs[bus.i_rs2_index];

  // The last outstanding write landing this cycle is covered by the bypass.
  assign w_hazard_rs1 = bus.i_rs1_used && (bus.i_rs1_index != '0) &&
                        w_nonzero[bus.i_rs1_index] &&
                        !(w_wb && bus.i_rd_index == bus.i_rs1_index && w_last[bus.i_rs1_index]);
  assign w_hazard_rs2 = bus.i_rs2_used && (bus.i_rs2_index != '0) &&
                        w_nonzero[bus.i_rs2_index] &&
                        !(w_wb && bus.i_rd_index == bus.i_rs2_index && w_last[bus.i_rs2_index]);
  assign bus.o_hazard = w_hazard_rs1 | w_hazard_rs2;

  assign bus.o_sb_underflow = r_sb_underflow;

  // NOTE: the array is reset because architectural state must read as zero
  // after reset; a plain storage RAM would normally be left unreset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb) begin
      r_regs[bus.i_rd_index] <= bus.i_rd_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sb_underflow <= 1'b0;
    else       r_sb_underflow <= r_sb_underflow | (|w_underflow);
  end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench: vector table for read/bypass/hazard behaviour, hand
// sequences for saturation, underflow and async reset, and a write scoreboard.
module tb_reg_file_scoreboard;
  import rv_pkg::*;

  logic i_clk;
  logic i_rst;
  int   n_checks;
  int   n_errors;

  reg_file_scoreboard_if bus ();

  reg_file_scoreboard dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [63:0] rd_data;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        iv;
    logic [4:0]  ird;
    logic        iwe;
    logic [63:0] e_rs1;
    logic [63:0] e_rs2;
    logic        e_haz;
    logic        e_full;
    logic        e_uf;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
  } wr_t;

  vec_t vecs [22];
  wr_t  sb_q [$];

  function automatic vec_t mk(logic we, logic [4:0] wi, logic [63:0] wd,
                              logic [4:0] s1, logic u1, logic [4:0] s2, logic u2,
                              logic iv, logic [4:0] ir, logic iw,
                              logic [63:0] e1, logic [63:0] e2,
                              logic eh, logic ef, logic eu);
    vec_t v;
    v.rd_we = we; v.rd_idx = wi; v.rd_data = wd;
    v.rs1 = s1; v.u1 = u1; v.rs2 = s2; v.u2 = u2;
    v.iv = iv; v.ird = ir; v.iwe = iw;
    v.e_rs1 = e1; v.e_rs2 = e2; v.e_haz = eh; v.e_full = ef; v.e_uf = eu;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.i_rd_we = 1'b0; bus.i_rd_index = '0; bus.i_rd_data = '0;
    bus.i_rs1_index = '0; bus.i_rs2_index = '0;
    bus.i_rs1_used = 1'b0; bus.i_rs2_used = 1'b0;
    bus.i_issue_valid = 1'b0; bus.i_issue_rd = '0; bus.i_issue_we = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.i_rd_we = v.rd_we; bus.i_rd_index = v.rd_idx; bus.i_rd_data = v.rd_data;
    bus.i_rs1_index = v.rs1; bus.i_rs1_used = v.u1;
    bus.i_rs2_index = v.rs2; bus.i_rs2_used = v.u2;
    bus.i_issue_valid = v.iv; bus.i_issue_rd = v.ird; bus.i_issue_we = v.iwe;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [63:0] x5_val;
    wr_t         w;
    logic [4:0]  sb_regs [6];

    n_checks = 0;
    n_errors = 0;
    x5_val   = '0;
    sb_regs  = '{5'd5, 5'd13, 5'd20, 5'd21, 5'd30, 5'd31};

    vecs[0]  = mk(0, 0, 0,                      0, 0, 0, 0,   1, 7, 1,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 7, 64'hDEAD_BEEF_0123_4567, 7, 1, 0, 0,   0, 0, 0,  64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,                      7, 1, 0, 0,   0, 0, 0,  64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, '1,                     0, 1, 0, 0,   0, 0, 0,  0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0,                      0, 1, 0, 1,   0, 0, 0,  0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0,                      0, 0, 9, 0,   1, 9, 1,  0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 9, 64'h55,                 0, 0, 9, 1,   0, 0, 0,  0, 64'h55, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0,                      0, 0, 9, 1,   0, 0, 0,  0, 64'h55, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0,                      3, 1, 0, 0,   1, 3, 1,  0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0,                      3, 1, 0, 0,   0, 0, 0,  0, 0, 1, 0, 0);
    vecs[10] = mk(0, 0, 0,                      3, 1, 0, 0,   0, 3, 0,  0, 0, 1, 0, 0);
    vecs[11] = mk(1, 3, 64'h33,                 3, 1, 0, 0,   0, 0, 0,  64'h33, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0,                      3, 1, 0, 0,   0, 0, 0,  64'h33, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0,                      3, 0, 0, 0,   1, 3, 1,  64'h33, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0,                      3, 0, 0, 0,   0, 0, 0,  64'h33, 0, 0, 0, 0);
    vecs[15] = mk(1, 3, 64'h44,                 3, 0, 0, 0,   0, 0, 0,  64'h44, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0,                      3, 1, 10, 1,  1, 10, 1, 64'h44, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0,                      3, 1, 10, 1,  0, 0, 0,  64'h44, 0, 1, 0, 0);
    vecs[18] = mk(1, 10, 64'hA0,                3, 1, 10, 1,  0, 0, 0,  64'h44, 64'hA0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0,                      0, 0, 10, 1,  0, 0, 0,  0, 64'hA0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0,                      0, 0, 0, 0,   1, 11, 0, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0,                      11, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);

    // Power-on reset.
    idle();
    i_rst = 1'b1;
    bus.i_rs1_index = 5'd5;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset rs1", bus.o_rs1_data, 64'h0);
    check("reset hazard", 64'(bus.o_hazard), 64'h0);
    check("reset full", 64'(bus.o_issue_full), 64'h0);
    check("reset underflow", 64'(bus.o_sb_underflow), 64'h0);
    i_rst = 1'b0;
    idle();
    tick();

    // Table-driven vectors: outputs checked mid-cycle, before the edge.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i]);
      #3;
      check($sformatf("vec%0d rs1", i), bus.o_rs1_data, vecs[i].e_rs1);
      check($sformatf("vec%0d rs2", i), bus.o_rs2_data, vecs[i].e_rs2);
      check($sformatf("vec%0d hazard", i), 64'(bus.o_hazard), 64'(vecs[i].e_haz));
      check($sformatf("vec%0d full", i), 64'(bus.o_issue_full), 64'(vecs[i].e_full));
      check($sformatf("vec%0d underflow", i), 64'(bus.o_sb_underflow), 64'(vecs[i].e_uf));
      tick();
    end
    idle();

    // Saturation on x4: three issues fill the counter, the fourth is ignored.
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd4; bus.i_issue_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      check($sformatf("sat issue%0d full", k), 64'(bus.o_issue_full), 64'(k == 3));
      tick();
    end
    idle();
    bus.i_issue_rd = 5'd4; bus.i_rs1_index = 5'd4; bus.i_rs1_used = 1'b1;
    #3;
    check("sat held full", 64'(bus.o_issue_full), 64'h1);
    check("sat hazard", 64'(bus.o_hazard), 64'h1);
    tick();
    // Write-back 3->2 while a blocked issue is presented.
    bus.i_rd_we = 1'b1; bus.i_rd_index = 5'd4; bus.i_rd_data = 64'h41;
    bus.i_issue_valid = 1'b1; bus.i_issue_we = 1'b1;
    #3;
    check("sat wb1 full", 64'(bus.o_issue_full), 64'h1);
    tick();
    // Simultaneous issue and write-back at count 2 keeps it at 2.
    bus.i_rd_data = 64'h42;
    #3;
    check("sat both full", 64'(bus.o_issue_full), 64'h0);
    check("sat both hazard", 64'(bus.o_hazard), 64'h1);
    tick();
    bus.i_issue_valid = 1'b0; bus.i_rd_data = 64'h43;
    #3;
    check("sat cnt2 wb hazard", 64'(bus.o_hazard), 64'h1);
    check("sat cnt2 wb bypass", bus.o_rs1_data, 64'h43);
    tick();
    bus.i_rd_data = 64'h44;
    #3;
    check("sat last wb hazard", 64'(bus.o_hazard), 64'h0);
    tick();
    bus.i_rd_we = 1'b0;
    #3;
    check("sat drained hazard", 64'(bus.o_hazard), 64'h0);
    check("sat drained data", bus.o_rs1_data, 64'h44);
    check("sat no underflow", 64'(bus.o_sb_underflow), 64'h0);
    tick();
    idle();

    // Scoreboard phase: issue, then write back random data, then read back.
    for (int k = 0; k < 6; k++) begin
      bus.i_issue_valid = 1'b1; bus.i_issue_we = 1'b1; bus.i_issue_rd = sb_regs[k];
      tick();
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      w.idx  = sb_regs[k];
      w.data = {$urandom(), $urandom()};
      if (w.idx == 5'd5) x5_val = w.data;
      sb_q.push_back(w);
      bus.i_rd_we = 1'b1; bus.i_rd_index = w.idx; bus.i_rd_data = w.data;
      bus.i_rs1_index = w.idx; bus.i_rs1_used = 1'b1;
      #3;
      check($sformatf("sb wb x%0d hazard", w.idx), 64'(bus.o_hazard), 64'h0);
      tick();
    end
    idle();
    while (sb_q.size() > 0) begin
      w = sb_q.pop_front();
      bus.i_rs1_index = w.idx; bus.i_rs2_index = w.idx;
      bus.i_rs1_used = 1'b1; bus.i_rs2_used = 1'b1;
      #3;
      check($sformatf("sb rs1 x%0d", w.idx), bus.o_rs1_data, w.data);
      check($sformatf("sb rs2 x%0d", w.idx), bus.o_rs2_data, w.data);
      check($sformatf("sb hazard x%0d", w.idx), 64'(bus.o_hazard), 64'h0);
      tick();
    end
    idle();
    check("sb no underflow", 64'(bus.o_sb_underflow), 64'h0);

    // Underflow: write-back to x12 with nothing issued.
    bus.i_rd_we = 1'b1; bus.i_rd_index = 5'd12; bus.i_rd_data = 64'h1212;
    bus.i_rs1_index = 5'd12;
    #3;
    check("uf bypass", bus.o_rs1_data, 64'h1212);
    check("uf not yet", 64'(bus.o_sb_underflow), 64'h0);
    tick();
    bus.i_rd_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      check($sformatf("uf sticky%0d", k), 64'(bus.o_sb_underflow), 64'h1);
      check($sformatf("uf data%0d", k), bus.o_rs1_data, 64'h1212);
      tick();
    end

    // Async reset mid-cycle with a pending write on x6.
    bus.i_issue_valid = 1'b1; bus.i_issue_we = 1'b1; bus.i_issue_rd = 5'd6;
    tick();
    idle();
    bus.i_rs1_index = 5'd5; bus.i_rs2_index = 5'd6; bus.i_rs2_used = 1'b1;
    #3;
    check("pre-rst x5", bus.o_rs1_data, x5_val);
    check("pre-rst hazard", 64'(bus.o_hazard), 64'h1);
    check("pre-rst underflow", 64'(bus.o_sb_underflow), 64'h1);
    #1;
    i_rst = 1'b1;
    #1;
    check("async rst x5", bus.o_rs1_data, 64'h0);
    check("async rst hazard", 64'(bus.o_hazard), 64'h0);
    check("async rst underflow", 64'(bus.o_sb_underflow), 64'h0);
    tick();
    i_rst = 1'b0;
    // A write-back still in flight across reset counts as underflow.
    bus.i_rd_we = 1'b1; bus.i_rd_index = 5'd6; bus.i_rd_data = 64'h66;
    #3;
    check("post-rst hazard", 64'(bus.o_hazard), 64'h0);
    tick();
    idle();
    bus.i_rs1_index = 5'd6;
    #3;
    check("post-rst underflow", 64'(bus.o_sb_underflow), 64'h1);
    check("post-rst data", bus.o_rs1_data, 64'h66);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
